// File: rtl/csr_access_unit.sv
// Zicsr initiator: probes a CSR with a non-modifying read, then issues an
// optional set/clear write and returns the old value to the pipeline.
module csr_access_unit #(
  parameter bit RO_CHECK = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [11:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_nowr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_illegal_o,
  output logic        csr_en_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_set_o,
  output logic [31:0] csr_clear_o,
  input  logic        csr_ack_i,
  input  logic [31:0] csr_value_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;

  state_t      state, state_d;
  logic [1:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        nowr_q, nowr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        illegal_q, illegal_d;
  logic        en_q, en_d;
  logic [11:0] bus_addr_q, bus_addr_d;
  logic [31:0] set_q, set_d;
  logic [31:0] clear_q, clear_d;
  logic        wr_req;
  logic        bad;

  assign wr_req = (op_q == OP_RW) || !nowr_q;
  assign bad    = !csr_ack_i ||
                  (RO_CHECK && (addr_q[11:10] == 2'b11) && wr_req);

  always_comb begin
    state_d    = state;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    nowr_d     = nowr_q;
    rdata_d    = rdata_q;
    illegal_d  = illegal_q;
    en_d       = 1'b0;
    bus_addr_d = bus_addr_q;
    set_d      = '0;
    clear_d    = '0;
    unique case (state)
      IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          nowr_d  = req_nowr_i;
          if (req_op_i == 2'b00) begin
            illegal_d = 1'b1;
            rdata_d   = '0;
            state_d   = RESP;
          end else begin
            en_d       = 1'b1;
            bus_addr_d = req_addr_i;
            state_d    = READ;
          end
        end
      end
      READ: begin
        if (bad) begin
          illegal_d = 1'b1;
          rdata_d   = '0;
          state_d   = RESP;
        end else begin
          illegal_d = 1'b0;
          rdata_d   = csr_value_i;
          if (wr_req) begin
            // registered so the write strobe appears cleanly in WRITE
            en_d    = 1'b1;
            state_d = WRITE;
            unique case (op_q)
              OP_RW: begin
                set_d   = wdata_q;
                clear_d = ~wdata_q;
              end
              OP_RS: set_d = wdata_q;
              default: clear_d = wdata_q;
            endcase
          end else begin
            state_d = RESP;
          end
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      nowr_q     <= 1'b0;
      rdata_q    <= '0;
      illegal_q  <= 1'b0;
      en_q       <= 1'b0;
      bus_addr_q <= '0;
      set_q      <= '0;
      clear_q    <= '0;
    end else begin
      state      <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      nowr_q     <= nowr_d;
      rdata_q    <= rdata_d;
      illegal_q  <= illegal_d;
      en_q       <= en_d;
      bus_addr_q <= bus_addr_d;
      set_q      <= set_d;
      clear_q    <= clear_d;
    end
  end

  assign req_ready_o   = (state == IDLE);
  assign rsp_valid_o   = (state == RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_illegal_o = illegal_q;
  assign csr_en_o      = en_q;
  assign csr_addr_o    = bus_addr_q;
  assign csr_set_o     = set_q;
  assign csr_clear_o   = clear_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: responder array on the bus plus an
// independent per-request reference model of the expected outcome.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_nowr = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_set;
  logic [31:0] csr_clear;
  logic        csr_ack;
  logic [31:0] csr_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_access_unit #(.RO_CHECK(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_nowr_i(req_nowr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_illegal_o(rsp_illegal),
    .csr_en_o(csr_en), .csr_addr_o(csr_addr),
    .csr_set_o(csr_set), .csr_clear_o(csr_clear),
    .csr_ack_i(csr_ack), .csr_value_i(csr_value)
  );

  logic [31:0] mem   [0:4095];
  logic [31:0] model [0:4095];

  function automatic bit mapped(input logic [11:0] a);
    return a == 12'h305 || a == 12'h341 || a == 12'h300 || a == 12'hC00;
  endfunction

  assign csr_ack   = csr_en && mapped(csr_addr);
  assign csr_value = csr_ack ? mem[csr_addr] : 32'hDEAD_BEEF;

  // responders; 0xC00 is a read-only counter-style register
  always @(posedge clk)
    if (csr_en && mapped(csr_addr) && csr_addr != 12'hC00)
      mem[csr_addr] = (mem[csr_addr] & ~csr_clear) | csr_set;

  int          en_cnt;
  logic [31:0] pr_set, pr_clr, wr_set, wr_clr;

  always @(posedge clk)
    if (csr_en) begin
      if (en_cnt == 0) begin
        pr_set = csr_set;
        pr_clr = csr_clear;
      end else begin
        wr_set = csr_set;
        wr_clr = csr_clear;
      end
      en_cnt++;
    end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL wait_ready: req_ready=%0b required 1", req_ready);
    end
  endtask

  task automatic drive_accept(input logic [1:0] op, input logic [11:0] a,
                              input logic [31:0] w, input logic nw);
    en_cnt = 0;
    pr_set = '1; pr_clr = '1; wr_set = '1; wr_clr = '1;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = w;
    req_nowr  = nw;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = 12'($urandom);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] w, input logic nw, input int hold);
    logic [31:0] e_rdata, e_new, e_set, e_clr;
    logic        e_ill;
    int          e_lat, e_en, lat;
    bit          wr;
    wr = (op == 2'b01) || (op != 2'b00 && !nw);
    e_set = '0; e_clr = '0; e_rdata = '0; e_ill = 1'b0;
    e_new = model[a];
    e_lat = 2; e_en = 1;
    if (op == 2'b00) begin
      e_ill = 1'b1; e_lat = 1; e_en = 0;
    end else if (!mapped(a) || (a[11:10] == 2'b11 && wr)) begin
      e_ill = 1'b1;
    end else begin
      e_rdata = model[a];
      if (wr) begin
        e_lat = 3; e_en = 2;
        case (op)
          2'b01: begin e_new = w; e_set = w; e_clr = ~w; end
          2'b10: begin e_new = model[a] | w; e_set = w; end
          default: begin e_new = model[a] & ~w; e_clr = w; end
        endcase
      end
    end
    wait_ready();
    drive_accept(op, a, w, nw);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== e_lat) begin
      errors++;
      $display("FAIL latency a=%h op=%0d: got %0d required %0d", a, op, lat, e_lat);
    end
    checks++;
    if (rsp_rdata !== e_rdata) begin
      errors++;
      $display("FAIL rdata a=%h op=%0d: got %h required %h", a, op, rsp_rdata, e_rdata);
    end
    checks++;
    if (rsp_illegal !== e_ill) begin
      errors++;
      $display("FAIL illegal a=%h op=%0d: got %0b required %0b", a, op, rsp_illegal, e_ill);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e_rdata || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc %0d: valid=%0b rdata=%h ready=%0b required 1 %h 0",
                 i, rsp_valid, rsp_rdata, req_ready, e_rdata);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: valid=%0b ready=%0b required 0 1", rsp_valid, req_ready);
    end
    checks++;
    if (en_cnt !== e_en) begin
      errors++;
      $display("FAIL bus_cycles a=%h op=%0d: got %0d required %0d", a, op, en_cnt, e_en);
    end
    if (e_en >= 1) begin
      checks++;
      if (pr_set !== 32'h0 || pr_clr !== 32'h0) begin
        errors++;
        $display("FAIL probe: set=%h clear=%h required 0 0", pr_set, pr_clr);
      end
    end
    if (e_en == 2) begin
      checks++;
      if (wr_set !== e_set || wr_clr !== e_clr) begin
        errors++;
        $display("FAIL write a=%h: set=%h clear=%h required %h %h",
                 a, wr_set, wr_clr, e_set, e_clr);
      end
    end
    model[a] = e_new;
    checks++;
    if (mem[a] !== model[a]) begin
      errors++;
      $display("FAIL csr_value a=%h: got %h required %h", a, mem[a], model[a]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
        rsp_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: ready=%0b valid=%0b rdata=%h ill=%0b required 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_illegal);
    end
    checks++;
    if (csr_en !== 1'b0 || csr_addr !== 12'h0 || csr_set !== 32'h0 ||
        csr_clear !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: en=%0b addr=%h set=%h clear=%h required 0 0 0 0",
               csr_en, csr_addr, csr_set, csr_clear);
    end
    rst = 1'b0;
  endtask

  task automatic test_plan();
    do_req(2'b01, 12'h305, 32'h8000_0004, 1'b0, 0);
    do_req(2'b10, 12'h305, 32'h0000_0010, 1'b0, 0);
    do_req(2'b11, 12'h305, 32'hFFFF_FFFF, 1'b1, 0);
    do_req(2'b11, 12'h341, 32'h0000_00FF, 1'b0, 1);
  endtask

  task automatic test_illegal();
    do_req(2'b01, 12'h7C0, 32'h1234_5678, 1'b0, 0);
    do_req(2'b10, 12'hC00, 32'h0000_0001, 1'b0, 0);
    do_req(2'b10, 12'hC00, 32'h0000_0000, 1'b1, 0);
    do_req(2'b01, 12'hC00, 32'h0000_0000, 1'b1, 0);
    do_req(2'b00, 12'h305, 32'hFFFF_FFFF, 1'b0, 0);
  endtask

  task automatic test_hold();
    do_req(2'b10, 12'h341, 32'h0, 1'b1, 5);
    do_req(2'b00, 12'h300, 32'h0, 1'b0, 5);
  endtask

  task automatic test_random();
    logic [11:0] addrs [6];
    addrs = '{12'h305, 12'h341, 12'h300, 12'hC00, 12'h7C0, 12'hF11};
    for (int i = 0; i < 40; i++)
      do_req(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 5)],
             $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    w = $urandom;
    wait_ready();
    drive_accept(2'b01, 12'h341, w, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (csr_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
        en_cnt !== 1 || mem[12'h341] !== model[12'h341]) begin
      errors++;
      $display("FAIL reset_in_read: en=%0b valid=%0b ready=%0b cyc=%0d val=%h required 0 0 1 1 %h",
               csr_en, rsp_valid, req_ready, en_cnt, mem[12'h341], model[12'h341]);
    end
    w = $urandom;
    drive_accept(2'b01, 12'h341, w, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (csr_en !== 1'b1 || csr_set !== w || csr_clear !== ~w) begin
      errors++;
      $display("FAIL in_write: en=%0b set=%h clear=%h required 1 %h %h",
               csr_en, csr_set, csr_clear, w, ~w);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (csr_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_write: en=%0b valid=%0b ready=%0b required 0 0 1",
               csr_en, rsp_valid, req_ready);
    end
    model[12'h341] = w;
    do_req(2'b10, 12'h341, 32'h0, 1'b1, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]   = '0;
      model[i] = '0;
    end
    mem[12'h305] = 32'h0000_0100; model[12'h305] = 32'h0000_0100;
    mem[12'h341] = 32'hCAFE_0000; model[12'h341] = 32'hCAFE_0000;
    mem[12'h300] = 32'h0000_1888; model[12'h300] = 32'h0000_1888;
    mem[12'hC00] = 32'h1234_5678; model[12'hC00] = 32'h1234_5678;
    en_cnt = 0;
    test_reset();
    test_plan();
    test_illegal();
    test_hold();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
